// File: rtl/regfile_writeback_queue_pkg.sv
// Shared types and sizes for the register-file writeback queue.
// One queued result is a destination register plus its data word.
package regfile_writeback_queue_pkg;

  localparam int AW        = 5;
  localparam int DW        = 32;
  localparam int REG_COUNT = 32;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wbq_entry_t;

endpackage

// File: rtl/regfile_writeback_queue_fwd_match.sv
// Forwarding lookup for one read port: finds the youngest pending entry whose rd
// matches addr. Entries arrive in age order, index 0 oldest.
module wbq_fwd_match
  import regfile_writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wbq_entry_t [DEPTH-1:0] entries,
  input  logic [DEPTH-1:0]       valid,
  input  logic [AW-1:0]          addr,
  output logic                   hit,
  output logic [DW-1:0]          data
);

  // Higher index is younger, so a later match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = {DW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      hit  = hit | (valid[i] && (entries[i].rd == addr));
      data = (valid[i] && (entries[i].rd == addr)) ? entries[i].data : data;
    end
  end

endmodule

// File: rtl/regfile_writeback_queue.sv
// In-order writeback queue between the ALU/memory stages and the register-file
// write port, with forwarding of still-pending results to two read addresses.
module regfile_writeback_queue
  import regfile_writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mem_valid,
  input  logic [AW-1:0]            mem_rd,
  input  logic [DW-1:0]            mem_data,
  output logic                     mem_ready,
  input  logic                     alu_valid,
  input  logic [AW-1:0]            alu_rd,
  input  logic [DW-1:0]            alu_data,
  output logic                     alu_ready,
  output logic [AW-1:0]            Rdst,
  output logic [DW-1:0]            wdata,
  output logic                     writereg,
  input  logic [AW-1:0]            Rsrc1,
  input  logic [AW-1:0]            Rsrc2,
  output logic                     fwd1_hit,
  output logic                     fwd2_hit,
  output logic [DW-1:0]            fwd1_data,
  output logic [DW-1:0]            fwd2_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] FREE_ONE = CW'(1);
  localparam logic [CW-1:0] FREE_TWO = CW'(2);

  wbq_entry_t [DEPTH-1:0] store_r;
  logic [CW-1:0]          rd_ptr_r;
  logic [CW-1:0]          wr_ptr_r;

  logic [CW-1:0]          count_s;
  logic [CW-1:0]          free_s;
  logic                   empty_s;
  logic                   mem_fire_s;
  logic                   alu_fire_s;
  logic [CW-1:0]          alu_slot_s;
  wbq_entry_t             head_s;
  wbq_entry_t [DEPTH-1:0] aged_s;
  logic [DEPTH-1:0]       aged_valid_s;

  assign count_s = wr_ptr_r - rd_ptr_r;
  assign free_s  = DEPTH_C - count_s;
  assign empty_s = (count_s == {CW{1'b0}});
  assign count   = count_s;

  // Readiness uses only start-of-cycle occupancy; a same-cycle pop is not credited.
  assign mem_ready  = (free_s >= FREE_ONE);
  assign alu_ready  = (free_s >= FREE_TWO) || ((free_s >= FREE_ONE) && !mem_valid);
  assign mem_fire_s = mem_valid && mem_ready;
  assign alu_fire_s = alu_valid && alu_ready;
  assign alu_slot_s = wr_ptr_r + CW'(mem_fire_s);

  // Queue storage and pointers: memory result is older than a same-cycle ALU result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_r  <= {(DEPTH * (AW + DW)){1'b0}};
      rd_ptr_r <= {CW{1'b0}};
      wr_ptr_r <= {CW{1'b0}};
    end else begin
      if (mem_fire_s) begin
        store_r[wr_ptr_r[PW-1:0]] <= '{rd: mem_rd, data: mem_data};
      end
      if (alu_fire_s) begin
        store_r[alu_slot_s[PW-1:0]] <= '{rd: alu_rd, data: alu_data};
      end
      wr_ptr_r <= wr_ptr_r + CW'(mem_fire_s) + CW'(alu_fire_s);
      rd_ptr_r <= rd_ptr_r + CW'(!empty_s);
    end
  end

  // Head entry drives the regfile write port; zeroed while empty.
  always_comb begin
    head_s   = store_r[rd_ptr_r[PW-1:0]];
    writereg = !empty_s;
    if (empty_s) begin
      Rdst  = {AW{1'b0}};
      wdata = {DW{1'b0}};
    end else begin
      Rdst  = head_s.rd;
      wdata = head_s.data;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_age
    logic [PW-1:0] slot_s;
    assign slot_s          = rd_ptr_r[PW-1:0] + PW'(g);
    assign aged_s[g]       = store_r[slot_s];
    assign aged_valid_s[g] = (CW'(g) < count_s);
  end

  wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
    .entries (aged_s),
    .valid   (aged_valid_s),
    .addr    (Rsrc1),
    .hit     (fwd1_hit),
    .data    (fwd1_data)
  );

  wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
    .entries (aged_s),
    .valid   (aged_valid_s),
    .addr    (Rsrc2),
    .hit     (fwd2_hit),
    .data    (fwd2_data)
  );

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed vector table plus hand-written sequences and a queue model for
// the writeback queue.
module tb_regfile_writeback_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, alu_valid;
  logic [4:0]  mem_rd, alu_rd, Rsrc1, Rsrc2, Rdst;
  logic [31:0] mem_data, alu_data, wdata, fwd1_data, fwd2_data;
  logic        mem_ready, alu_ready, writereg, fwd1_hit, fwd2_hit;
  logic [2:0]  count;

  regfile_writeback_queue dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .Rdst(Rdst), .wdata(wdata), .writereg(writereg),
    .Rsrc1(Rsrc1), .Rsrc2(Rsrc2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic mv; logic [4:0] mrd; logic [31:0] mdata;
    logic av; logic [4:0] ard; logic [31:0] adata;
    logic [4:0] s1; logic [4:0] s2;
    logic e_wr; logic [4:0] e_rdst; logic [31:0] e_wdata;
    logic e_mr; logic e_ar; logic [2:0] e_cnt;
    logic e_h1; logic [31:0] e_d1; logic e_h2; logic [31:0] e_d2;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  vec_t vecs[$];
  ent_t q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic ok, input string detail);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  task automatic add(input logic mv, input logic [4:0] mrd, input logic [31:0] mdata,
                     input logic av, input logic [4:0] ard, input logic [31:0] adata,
                     input logic [4:0] s1, input logic [4:0] s2,
                     input logic wr, input logic [4:0] rdst, input logic [31:0] wd,
                     input logic mr, input logic ar, input logic [2:0] cnt,
                     input logic h1, input logic [31:0] d1, input logic h2, input logic [31:0] d2);
    vec_t v;
    v.mv = mv; v.mrd = mrd; v.mdata = mdata; v.av = av; v.ard = ard; v.adata = adata;
    v.s1 = s1; v.s2 = s2; v.e_wr = wr; v.e_rdst = rdst; v.e_wdata = wd;
    v.e_mr = mr; v.e_ar = ar; v.e_cnt = cnt; v.e_h1 = h1; v.e_d1 = d1; v.e_h2 = h2; v.e_d2 = d2;
    vecs.push_back(v);
  endtask

  function automatic string got_str();
    return $sformatf("got wr=%0b rd=%0d wd=%h mr=%0b ar=%0b cnt=%0d h1=%0b d1=%h h2=%0b d2=%h",
                     writereg, Rdst, wdata, mem_ready, alu_ready, count,
                     fwd1_hit, fwd1_data, fwd2_hit, fwd2_data);
  endfunction

  // Compare DUT against the queue model, then apply the clock-edge effect to the model.
  task automatic model_step(input string name, output logic mf, output logic af);
    int free;
    logic e_wr, e_mr, e_ar, e_h1, e_h2;
    logic [4:0] e_rdst;
    logic [31:0] e_wd, e_d1, e_d2;
    free = 4 - q.size();
    e_mr = (free >= 1);
    e_ar = (free >= 2) || ((free >= 1) && !mem_valid);
    e_wr = (q.size() != 0);
    e_rdst = e_wr ? q[0].rd : 5'd0;
    e_wd = e_wr ? q[0].data : 32'd0;
    e_h1 = 1'b0; e_d1 = 32'd0; e_h2 = 1'b0; e_d2 = 32'd0;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].rd == Rsrc1) begin e_h1 = 1'b1; e_d1 = q[i].data; end
      if (q[i].rd == Rsrc2) begin e_h2 = 1'b1; e_d2 = q[i].data; end
    end
    chk(name, (writereg === e_wr) && (Rdst === e_rdst) && (wdata === e_wd) &&
              (mem_ready === e_mr) && (alu_ready === e_ar) && (count === 3'(q.size())) &&
              (fwd1_hit === e_h1) && (fwd1_data === e_d1) && (fwd2_hit === e_h2) && (fwd2_data === e_d2),
        $sformatf("%s exp wr=%0b rd=%0d wd=%h mr=%0b ar=%0b cnt=%0d h1=%0b d1=%h h2=%0b d2=%h",
                  got_str(), e_wr, e_rdst, e_wd, e_mr, e_ar, q.size(), e_h1, e_d1, e_h2, e_d2));
    mf = mem_valid && e_mr;
    af = alu_valid && e_ar;
    if (e_wr) void'(q.pop_front());
    if (mf) q.push_back('{rd: mem_rd, data: mem_data});
    if (af) q.push_back('{rd: alu_rd, data: alu_data});
  endtask

  initial begin
    logic mf, af;
    int accepted, dut_writes, cyc;
    mf = 1'b0; af = 1'b0; accepted = 0; dut_writes = 0; cyc = 0;

    rst_n = 1'b0;
    mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    Rsrc1 = 5'd0; Rsrc2 = 5'd0;
    #2;
    chk("reset_state", !writereg && Rdst == 5'd0 && wdata == 32'd0 && count == 3'd0 &&
                       mem_ready && alu_ready && !fwd1_hit && !fwd2_hit &&
                       fwd1_data == 32'd0 && fwd2_data == 32'd0, got_str());
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // mv mrd mdata          av ard adata          s1 s2  wr rd wdata        mr ar cnt h1 d1 h2 d2
    add(0,0,32'h0,           0,0,32'h0,            0,0,   0,0,32'h0,        1,1,0, 0,32'h0,0,32'h0);
    add(0,0,32'h0,           1,5,32'hDEADBEEF,     5,0,   0,0,32'h0,        1,1,0, 0,32'h0,0,32'h0);
    add(0,0,32'h0,           0,0,32'h0,            5,9,   1,5,32'hDEADBEEF, 1,1,1, 1,32'hDEADBEEF,0,32'h0);
    add(1,3,32'h11,          1,4,32'h22,           3,4,   0,0,32'h0,        1,1,0, 0,32'h0,0,32'h0);
    add(0,0,32'h0,           0,0,32'h0,            3,4,   1,3,32'h11,       1,1,2, 1,32'h11,1,32'h22);
    add(0,0,32'h0,           0,0,32'h0,            3,4,   1,4,32'h22,       1,1,1, 0,32'h0,1,32'h22);
    add(1,7,32'hA,           1,7,32'hB,            7,8,   0,0,32'h0,        1,1,0, 0,32'h0,0,32'h0);
    add(0,0,32'h0,           0,0,32'h0,            7,8,   1,7,32'hA,        1,1,2, 1,32'hB,0,32'h0);
    add(0,0,32'h0,           0,0,32'h0,            7,8,   1,7,32'hB,        1,1,1, 1,32'hB,0,32'h0);
    add(0,0,32'h0,           0,0,32'h0,            7,8,   0,0,32'h0,        1,1,0, 0,32'h0,0,32'h0);
    add(0,0,32'h0,           1,0,32'h5,            1,2,   0,0,32'h0,        1,1,0, 0,32'h0,0,32'h0);
    add(0,0,32'h0,           0,0,32'h0,            0,0,   1,0,32'h5,        1,1,1, 1,32'h5,1,32'h5);
    add(0,0,32'h0,           0,0,32'h0,            0,0,   0,0,32'h0,        1,1,0, 0,32'h0,0,32'h0);
    add(1,1,32'h10000001,    1,2,32'h10000002,     1,2,   0,0,32'h0,        1,1,0, 0,32'h0,0,32'h0);
    add(1,3,32'h10000003,    1,4,32'h10000004,     1,2,   1,1,32'h10000001, 1,1,2, 1,32'h10000001,1,32'h10000002);
    add(1,5,32'h10000005,    1,6,32'h10000006,     2,4,   1,2,32'h10000002, 1,0,3, 1,32'h10000002,1,32'h10000004);
    add(1,7,32'h10000007,    1,6,32'h10000006,     5,6,   1,3,32'h10000003, 1,0,3, 1,32'h10000005,0,32'h0);
    add(0,0,32'h0,           1,6,32'h10000006,     6,7,   1,4,32'h10000004, 1,1,3, 0,32'h0,1,32'h10000007);
    add(0,0,32'h0,           0,0,32'h0,            6,5,   1,5,32'h10000005, 1,1,3, 1,32'h10000006,1,32'h10000005);
    add(0,0,32'h0,           0,0,32'h0,            6,7,   1,7,32'h10000007, 1,1,2, 1,32'h10000006,1,32'h10000007);
    add(0,0,32'h0,           0,0,32'h0,            6,7,   1,6,32'h10000006, 1,1,1, 1,32'h10000006,0,32'h0);
    add(0,0,32'h0,           0,0,32'h0,            6,7,   0,0,32'h0,        1,1,0, 0,32'h0,0,32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      mem_valid = vecs[i].mv; mem_rd = vecs[i].mrd; mem_data = vecs[i].mdata;
      alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].adata;
      Rsrc1 = vecs[i].s1; Rsrc2 = vecs[i].s2;
      #1;
      chk($sformatf("vec%0d", i),
          writereg === vecs[i].e_wr && Rdst === vecs[i].e_rdst && wdata === vecs[i].e_wdata &&
          mem_ready === vecs[i].e_mr && alu_ready === vecs[i].e_ar && count === vecs[i].e_cnt &&
          fwd1_hit === vecs[i].e_h1 && fwd1_data === vecs[i].e_d1 &&
          fwd2_hit === vecs[i].e_h2 && fwd2_data === vecs[i].e_d2,
          $sformatf("%s exp wr=%0b rd=%0d wd=%h mr=%0b ar=%0b cnt=%0d h1=%0b d1=%h h2=%0b d2=%h",
                    got_str(), vecs[i].e_wr, vecs[i].e_rdst, vecs[i].e_wdata, vecs[i].e_mr,
                    vecs[i].e_ar, vecs[i].e_cnt, vecs[i].e_h1, vecs[i].e_d1, vecs[i].e_h2, vecs[i].e_d2));
    end

    // Random producers holding valid/data until accepted, checked against a queue model.
    @(negedge clk);
    mem_valid = 1'b0; alu_valid = 1'b0;
    q.delete();
    while (accepted < 100 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (mf) mem_valid = 1'b0;
      if (af) alu_valid = 1'b0;
      if (!mem_valid && $urandom_range(0, 3) != 0) begin
        mem_valid = 1'b1; mem_rd = 5'($urandom_range(0, 7)); mem_data = $urandom;
      end
      if (!alu_valid && $urandom_range(0, 3) != 0) begin
        alu_valid = 1'b1; alu_rd = 5'($urandom_range(0, 7)); alu_data = $urandom;
      end
      Rsrc1 = 5'($urandom_range(0, 7));
      Rsrc2 = 5'($urandom_range(0, 7));
      #1;
      if (writereg) dut_writes++;
      model_step("rand_cycle", mf, af);
      accepted += int'(mf) + int'(af);
    end
    chk("rand_budget", accepted >= 100, $sformatf("accepted %0d results in %0d cycles, need 100", accepted, cyc));

    @(negedge clk);
    mem_valid = 1'b0; alu_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      if (writereg) dut_writes++;
      model_step("rand_drain", mf, af);
    end
    chk("rand_totals", dut_writes == accepted && count == 3'd0,
        $sformatf("writes=%0d count=%0d, need writes=%0d count=0", dut_writes, count, accepted));

    // Asynchronous reset with three entries pending.
    @(negedge clk);
    mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'hC0;
    alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hC1;
    @(negedge clk);
    mem_rd = 5'd12; mem_data = 32'hC2;
    alu_rd = 5'd13; alu_data = 32'hC3;
    @(negedge clk);
    mem_valid = 1'b0; alu_valid = 1'b0; Rsrc1 = 5'd13; Rsrc2 = 5'd12;
    #1;
    chk("pre_reset", count == 3'd3 && writereg && Rdst == 5'd11 && wdata == 32'hC1 &&
                     fwd1_hit && fwd1_data == 32'hC3 && fwd2_hit && fwd2_data == 32'hC2,
        $sformatf("%s exp cnt=3 wr=1 rd=11 wd=c1 h1=1 d1=c3 h2=1 d2=c2", got_str()));
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset", !writereg && count == 3'd0 && !fwd1_hit && !fwd2_hit &&
                       Rdst == 5'd0 && wdata == 32'd0 && mem_ready && alu_ready,
        $sformatf("%s exp wr=0 cnt=0 h1=0 h2=0 rd=0 wd=0 mr=1 ar=1", got_str()));
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_reset%0d", k), !writereg && count == 3'd0,
          $sformatf("wr=%0b cnt=%0d, need wr=0 cnt=0", writereg, count));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
